ctrl_fsm: RTL and testbench
===========================

Name: ctrl_fsm

Overview:
- Main control state machine of the processor core. It produces the 4-bit `state` code that the control-signal decoder turns into gp_read, gp_write, latch_ula, grab_ula, pc_increment, rom_read and ula_operation.
- Consumes ROM and ULA handshakes, latches the fetched instruction, and exports its opcode and register fields.
- Sits between the instruction ROM, the ULA and the control-signal decoder.

Parameters:
- INSTR_W, 16, instruction word width; opcode is always bits [INSTR_W-1:INSTR_W-4].
- ULA_TIMEOUT, 15, maximum number of ULA_WAIT cycles before the error halt (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; enables instruction sequencing.
- resume  input  1  one-cycle pulse; leaves S_HALT.
- rom_data  input  INSTR_W  instruction word from the ROM.
- rom_valid  input  1  rom_data is valid this cycle.
- ula_done  input  1  ULA result is ready.
- state  output  4  current state code, shared `S_*` encoding.
- opcode  output  4  latched opcode.
- rd, rs, rt  output  4 each  latched register fields: [11:8], [7:4], [3:0].
- halted  output  1  high while in S_HALT.
- ula_err  output  1  sticky ULA timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=S_RESET, opcode/rd/rs/rt=0, halted=0, ula_err=0, timeout counter=0.
  - Reset asserted mid-instruction aborts the instruction. No partial store is held.
- State encoding (shared constants): S_RESET=0, S_FETCH=1, S_DECODE=2, S_ULA_OP=3, S_ULA_WAIT=4, S_STORE_RES=5, S_STORE_REG=6, S_HALT=7. Codes 8-15 are illegal and go to S_RESET on the next clock.
- S_RESET: go to S_FETCH when run=1, else stay.
- S_FETCH:
  - Stay until rom_valid=1.
  - On rom_valid, latch rom_data into the instruction register and go to S_DECODE.
  - run=0 does not abort a pending fetch.
- S_DECODE (1 cycle):
  - opcode 4'hF (HALT) -> S_HALT.
  - opcode 4'h0 (NOP) -> S_FETCH if run, else S_RESET.
  - Any other opcode -> S_ULA_OP.
- S_ULA_OP: exactly 1 cycle, then S_ULA_WAIT. Clears the timeout counter.
- S_ULA_WAIT:
  - ula_done=1 -> S_STORE_RES.
  - Otherwise the counter increments. When the counter reaches ULA_TIMEOUT with ula_done=0: set ula_err=1 and go to S_HALT.
  - If ula_done and the timeout occur in the same cycle, ula_done wins.
  - ula_done in any other state is ignored.
- S_STORE_RES (1 cycle) -> S_STORE_REG.
- S_STORE_REG (1 cycle) -> S_FETCH if run, else S_RESET.
- S_HALT:
  - halted=1 while in this state.
  - resume=1 -> S_FETCH, clears ula_err. halted drops on the next cycle.
  - run is ignored in S_HALT.
- Latency:
  - ULA instruction: minimum 6 cycles (FETCH with immediate rom_valid, DECODE, ULA_OP, ULA_WAIT with immediate done, STORE_RES, STORE_REG).
  - NOP: 2 cycles.
- opcode, rd, rs, rt change only on the FETCH->DECODE transition. They hold through HALT and through run=0.
- All outputs are registered or decoded directly from registered state. No input-to-output combinational path.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- When defined:
  - Adds output `retired` (16 bits). It is reset to 0 and increments by 1 on every exit from S_STORE_REG and every NOP exit from S_DECODE.
  - It wraps from 16'hFFFF to 0. HALT does not count.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- `S_*` state codes, OP_NOP=4'h0 and OP_HALT=4'hF go in the shared defines file, also used by the control-signal decoder.
- One natural sub-module: ula_watchdog (timeout counter, clear/enable inputs, `expired` output).
- Next-state logic and the instruction register stay in ctrl_fsm.

Test Plan:
1. Reset with run=1 and an instruction of opcode 4'h3 (rom_valid immediate, ula_done after 2 WAIT cycles) -> state sequence 0,1,2,3,4,4,5,6,1; opcode=3.
2. rom_data=16'h0000 (NOP) -> FETCH, DECODE, FETCH; no ULA states visited; `retired` +1 with INSTR_COUNT_EN.
3. ula_done held low in ULA_WAIT -> after ULA_TIMEOUT=15 wait cycles: ula_err=1, state=7, halted=1; resume pulse -> state=1, ula_err=0.
4. Instruction 16'hF000 -> HALT entered from DECODE; run toggling has no effect; opcode stays 4'hF.
5. rst_n pulsed low during S_ULA_WAIT -> state=0 immediately (async), all fields 0; run=0 after release keeps state=0.
6. run dropped during S_ULA_WAIT -> instruction completes through STORE_REG, then state=0 rather than 1.

Source files
------------

// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the core control state machine and the
// control-signal decoder: state codes, special opcodes, watchdog width.
package ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_ULA_OP    = 4'd3,
    S_ULA_WAIT  = 4'd4,
    S_STORE_RES = 4'd5,
    S_STORE_REG = 4'd6,
    S_HALT      = 4'd7
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Wide enough for the largest ULA timeout (255).
  localparam int WDOG_W = 8;

endpackage

// File: rtl/ctrl_fsm_ula_watchdog.sv
// ULA watchdog: counts ULA_WAIT cycles without a result and flags the
// last permitted cycle so the FSM can halt with an error.
module ctrl_fsm_ula_watchdog
  import ctrl_fsm_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] cnt_q;

  // Wait-cycle counter; cleared on ULA launch, saturates as a safety net.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != {WDOG_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The current wait cycle is the TIMEOUT-th one without a result.
  assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/ctrl_fsm.sv
// Main control state machine of the processor core. Sequences fetch,
// decode, ULA operation and result store, and holds the fetched
// instruction fields. Optional build macro INSTR_COUNT_EN adds a 16-bit
// retired-instruction counter output.
//
// state       | meaning
// S_RESET     | idle, waiting for run
// S_FETCH     | waiting for rom_valid, latches instruction
// S_DECODE    | dispatch on latched opcode
// S_ULA_OP    | launch ULA, clear watchdog
// S_ULA_WAIT  | waiting for ula_done or timeout
// S_STORE_RES | store ULA result
// S_STORE_REG | write back to register file
// S_HALT      | stopped until resume
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int ULA_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               resume,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               rom_valid,
  input  logic               ula_done,
  output logic [3:0]         state,
  output logic [3:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic               halted,
`ifdef INSTR_COUNT_EN
  output logic [15:0]        retired,
`endif
  output logic               ula_err
);

  state_t state_q, state_d;
  logic   wd_clear, wd_enable, wd_expired;
  logic   ir_load, err_set, err_clr;

  ctrl_fsm_ula_watchdog #(
    .TIMEOUT (ULA_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; undefined codes recover to S_RESET.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:     if (run) state_d = S_FETCH;
      S_FETCH:     if (rom_valid) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT)     state_d = S_HALT;
        else if (opcode == OP_NOP) state_d = run ? S_FETCH : S_RESET;
        else                       state_d = S_ULA_OP;
      end
      S_ULA_OP:    state_d = S_ULA_WAIT;
      S_ULA_WAIT: begin
        // A result arriving on the last permitted cycle still wins.
        if (ula_done)        state_d = S_STORE_RES;
        else if (wd_expired) state_d = S_HALT;
      end
      S_STORE_RES: state_d = S_STORE_REG;
      S_STORE_REG: state_d = run ? S_FETCH : S_RESET;
      S_HALT:      if (resume) state_d = S_FETCH;
      default:     state_d = S_RESET;
    endcase
  end

  // Outputs and internal strobes decoded from the registered state.
  always_comb begin
    state     = state_q;
    halted    = (state_q == S_HALT);
    wd_clear  = (state_q == S_ULA_OP);
    wd_enable = (state_q == S_ULA_WAIT) && !ula_done;
    ir_load   = (state_q == S_FETCH) && rom_valid;
    err_set   = (state_q == S_ULA_WAIT) && !ula_done && wd_expired;
    err_clr   = (state_q == S_HALT) && resume;
  end

  // Instruction register: fields only change on FETCH -> DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode <= '0;
      rd     <= '0;
      rs     <= '0;
      rt     <= '0;
    end else if (ir_load) begin
      opcode <= rom_data[INSTR_W-1 -: 4];
      rd     <= rom_data[11:8];
      rs     <= rom_data[7:4];
      rt     <= rom_data[3:0];
    end
  end

  // Sticky ULA timeout flag, cleared only when resuming from halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ula_err <= 1'b0;
    end else if (err_set) begin
      ula_err <= 1'b1;
    end else if (err_clr) begin
      ula_err <= 1'b0;
    end
  end

`ifdef INSTR_COUNT_EN
  logic retire;

  // An instruction retires on leaving STORE_REG or on a NOP leaving DECODE.
  always_comb begin
    retire = (state_q == S_STORE_REG) ||
             ((state_q == S_DECODE) && (opcode == OP_NOP));
  end

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm. Expected state sequences are queued
// per scenario and popped as the DUT advances, one entry per clock.
module tb_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        resume;
  logic [15:0] rom_data;
  logic        rom_valid;
  logic        ula_done;
  logic [3:0]  state;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic        halted;
  logic        ula_err;
`ifdef INSTR_COUNT_EN
  logic [15:0] retired;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_s;
  logic [15:0] exp_retired = 16'd0;

  ctrl_fsm #(
    .INSTR_W     (16),
    .ULA_TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .resume    (resume),
    .rom_data  (rom_data),
    .rom_valid (rom_valid),
    .ula_done  (ula_done),
    .state     (state),
    .opcode    (opcode),
    .rd        (rd),
    .rs        (rs),
    .rt        (rt),
    .halted    (halted),
`ifdef INSTR_COUNT_EN
    .retired   (retired),
`endif
    .ula_err   (ula_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; resume = 1'b0;
    rom_data = 16'h0000; rom_valid = 1'b0; ula_done = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_tests++;
    if ({opcode, rd, rs, rt} !== 16'h0000) begin n_fail++; $display("FAIL reset_fields: got %h expected 0000", {opcode, rd, rs, rt}); end
    n_tests++;
    if ({halted, ula_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {halted, ula_err}); end
`ifdef INSTR_COUNT_EN
    n_tests++;
    if (retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired); end
`endif
  endtask

  // Opcode 3, done on second wait cycle: 0,1,2,3,4,4,5,6,1.
  task automatic test_ula_instr();
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd1};
    for (int i = 0; i < 9; i++) begin
      exp_s = exp_q.pop_front();
      n_tests++;
      if (state !== exp_s) begin n_fail++; $display("FAIL ula_instr_seq[%0d]: got %0d expected %0d", i, state, exp_s); end
      case (i)
        0: begin rst_n = 1'b1; rom_data = 16'h3123; rom_valid = 1'b1; end
        2: rom_valid = 1'b0;
        5: ula_done = 1'b1;
        6: ula_done = 1'b0;
        default: ;
      endcase
      if (i != 8) @(negedge clk);
    end
    exp_retired = exp_retired + 16'd1;
    n_tests++;
    if ({opcode, rd, rs, rt} !== 16'h3123) begin n_fail++; $display("FAIL ula_instr_fields: got %h expected 3123", {opcode, rd, rs, rt}); end
  endtask

  // NOP: FETCH, DECODE, FETCH; no ULA states.
  task automatic test_nop();
    exp_q = '{4'd1, 4'd2, 4'd1, 4'd1};
    for (int i = 0; i < 4; i++) begin
      exp_s = exp_q.pop_front();
      n_tests++;
      if (state !== exp_s) begin n_fail++; $display("FAIL nop_seq[%0d]: got %0d expected %0d", i, state, exp_s); end
      case (i)
        0: begin rom_data = 16'h0000; rom_valid = 1'b1; end
        1: rom_valid = 1'b0;
        default: ;
      endcase
      if (i != 3) @(negedge clk);
    end
    exp_retired = exp_retired + 16'd1;
    n_tests++;
    if (opcode !== 4'h0) begin n_fail++; $display("FAIL nop_opcode: got %h expected 0", opcode); end
`ifdef INSTR_COUNT_EN
    n_tests++;
    if (retired !== exp_retired) begin n_fail++; $display("FAIL nop_retired: got %0d expected %0d", retired, exp_retired); end
`endif
  endtask

  // ula_done never arrives: 15 wait cycles, then halt with error.
  task automatic test_timeout();
    exp_q = '{4'd1, 4'd2, 4'd3};
    for (int k = 0; k < 15; k++) exp_q.push_back(4'd4);
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd1);
    for (int i = 0; i < 21; i++) begin
      exp_s = exp_q.pop_front();
      n_tests++;
      if (state !== exp_s) begin n_fail++; $display("FAIL timeout_seq[%0d]: got %0d expected %0d", i, state, exp_s); end
      case (i)
        0: begin rom_data = 16'h5ABC; rom_valid = 1'b1; end
        1: rom_valid = 1'b0;
        18: begin
          n_tests++;
          if ({halted, ula_err} !== 2'b11) begin n_fail++; $display("FAIL timeout_flags: got %b expected 11", {halted, ula_err}); end
          ula_done = 1'b1;
        end
        19: begin
          n_tests++;
          if (ula_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", ula_err); end
          ula_done = 1'b0;
          resume = 1'b1;
        end
        20: resume = 1'b0;
        default: ;
      endcase
      if (i != 20) @(negedge clk);
    end
    n_tests++;
    if ({halted, ula_err} !== 2'b00) begin n_fail++; $display("FAIL resume_flags: got %b expected 00", {halted, ula_err}); end
  endtask

  // HALT opcode: halt from DECODE, run toggling ignored, resume to FETCH.
  task automatic test_halt_instr();
    exp_q = '{4'd1, 4'd2, 4'd7, 4'd7, 4'd7, 4'd7, 4'd1};
    for (int i = 0; i < 7; i++) begin
      exp_s = exp_q.pop_front();
      n_tests++;
      if (state !== exp_s) begin n_fail++; $display("FAIL halt_seq[%0d]: got %0d expected %0d", i, state, exp_s); end
      case (i)
        0: begin rom_data = 16'hF000; rom_valid = 1'b1; end
        1: rom_valid = 1'b0;
        2: run = 1'b0;
        3: run = 1'b1;
        4: begin
          run = 1'b0;
          n_tests++;
          if ({halted, opcode} !== 5'b1_1111) begin n_fail++; $display("FAIL halt_opcode: got %b expected 11111", {halted, opcode}); end
        end
        5: resume = 1'b1;
        6: begin resume = 1'b0; run = 1'b1; end
        default: ;
      endcase
      if (i != 6) @(negedge clk);
    end
`ifdef INSTR_COUNT_EN
    n_tests++;
    if (retired !== exp_retired) begin n_fail++; $display("FAIL halt_retired: got %0d expected %0d", retired, exp_retired); end
`endif
  endtask

  // Async reset during ULA_WAIT aborts the instruction.
  task automatic test_async_reset();
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 4; i++) begin
      exp_s = exp_q.pop_front();
      n_tests++;
      if (state !== exp_s) begin n_fail++; $display("FAIL areset_pre[%0d]: got %0d expected %0d", i, state, exp_s); end
      case (i)
        0: begin rom_data = 16'h2456; rom_valid = 1'b1; end
        1: rom_valid = 1'b0;
        default: ;
      endcase
      if (i != 3) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_retired = 16'd0;
    n_tests++;
    if (state !== 4'd0) begin n_fail++; $display("FAIL areset_state: got %0d expected 0", state); end
    n_tests++;
    if ({opcode, rd, rs, rt} !== 16'h0000) begin n_fail++; $display("FAIL areset_fields: got %h expected 0000", {opcode, rd, rs, rt}); end
`ifdef INSTR_COUNT_EN
    n_tests++;
    if (retired !== 16'd0) begin n_fail++; $display("FAIL areset_retired: got %0d expected 0", retired); end
`endif
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '{4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 3; i++) begin
      exp_s = exp_q.pop_front();
      n_tests++;
      if (state !== exp_s) begin n_fail++; $display("FAIL areset_idle[%0d]: got %0d expected %0d", i, state, exp_s); end
      if (i != 2) @(negedge clk);
    end
  endtask

  // run dropped mid-instruction: completes, then returns to RESET.
  task automatic test_run_drop();
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd0};
    for (int i = 0; i < 9; i++) begin
      exp_s = exp_q.pop_front();
      n_tests++;
      if (state !== exp_s) begin n_fail++; $display("FAIL rundrop_seq[%0d]: got %0d expected %0d", i, state, exp_s); end
      case (i)
        0: begin run = 1'b1; rom_data = 16'h7111; rom_valid = 1'b1; end
        2: rom_valid = 1'b0;
        4: begin run = 1'b0; ula_done = 1'b1; end
        5: ula_done = 1'b0;
        default: ;
      endcase
      if (i != 8) @(negedge clk);
    end
    exp_retired = exp_retired + 16'd1;
    n_tests++;
    if (opcode !== 4'h7) begin n_fail++; $display("FAIL rundrop_opcode: got %h expected 7", opcode); end
`ifdef INSTR_COUNT_EN
    n_tests++;
    if (retired !== exp_retired) begin n_fail++; $display("FAIL rundrop_retired: got %0d expected %0d", retired, exp_retired); end
`endif
  endtask

  // ula_done on the 15th wait cycle beats the timeout.
  task automatic test_done_at_timeout();
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3};
    for (int k = 0; k < 15; k++) exp_q.push_back(4'd4);
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd6);
    exp_q.push_back(4'd1);
    for (int i = 0; i < 22; i++) begin
      exp_s = exp_q.pop_front();
      n_tests++;
      if (state !== exp_s) begin n_fail++; $display("FAIL edge_seq[%0d]: got %0d expected %0d", i, state, exp_s); end
      case (i)
        0: begin run = 1'b1; rom_data = 16'h4321; rom_valid = 1'b1; end
        2: rom_valid = 1'b0;
        18: ula_done = 1'b1;
        19: begin
          ula_done = 1'b0;
          n_tests++;
          if ({halted, ula_err} !== 2'b00) begin n_fail++; $display("FAIL edge_flags: got %b expected 00", {halted, ula_err}); end
        end
        default: ;
      endcase
      if (i != 21) @(negedge clk);
    end
    exp_retired = exp_retired + 16'd1;
`ifdef INSTR_COUNT_EN
    n_tests++;
    if (retired !== exp_retired) begin n_fail++; $display("FAIL edge_retired: got %0d expected %0d", retired, exp_retired); end
`endif
  endtask

  initial begin
    test_reset();
    test_ula_instr();
    test_nop();
    test_timeout();
    test_halt_instr();
    test_async_reset();
    test_run_drop();
    test_done_at_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
